// File: rtl/pc_control_unit.sv
// pc_control_unit: program counter register with parametrised next-PC source
// selection, conditional branch evaluation and exception entry/return.
module pc_control_unit #(
  parameter int unsigned           WIDTH       = 32,
  parameter int unsigned           NSRC        = 5,
  parameter int unsigned           SELW        = 3,
  parameter logic [WIDTH-1:0]      RESET_PC    = '0,
  parameter logic [WIDTH-1:0]      EXC_VECTOR  = 32'h0000_00FC,
  parameter logic [WIDTH-1:0]      EPC_OFFSET  = 4,
  parameter bit                    ALIGN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  input  logic [SELW-1:0]       src_sel,
  input  logic                  pc_write,
  input  logic                  pc_write_cond,
  input  logic [1:0]            branch_type,
  input  logic                  alu_zero,
  input  logic                  alu_neg,
  input  logic                  exc_req,
  input  logic [1:0]            exc_cause,
  input  logic                  eret,
  output logic [WIDTH-1:0]      pc_out,
  output logic [WIDTH-1:0]      epc_out,
  output logic [1:0]            cause_out,
  output logic                  in_handler,
  output logic                  double_fault,
  output logic                  sel_err
);

  typedef enum logic {RUN, HANDLER} state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'd3;

  state_t           state, state_n;
  logic [WIDTH-1:0] target;
  logic             sel_valid;
  logic             cond_ok;
  logic             taken;
  logic             misaligned;
  logic [WIDTH-1:0] pc_n, epc_n;
  logic [1:0]       cause_n;
  logic             df_n, sel_err_n;

  // Source mux: slice src_sel of src_bus; out-of-range selects flag invalid.
  always_comb begin
    target    = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (src_sel == SELW'(i)) begin
        target    = src_bus[i*WIDTH +: WIDTH];
        sel_valid = 1'b1;
      end
    end
  end

  // Branch condition from ALU flags and write-taken / misalignment decode.
  always_comb begin
    unique case (branch_type)
      2'd0:    cond_ok = alu_zero;
      2'd1:    cond_ok = !alu_zero;
      2'd2:    cond_ok = alu_neg | alu_zero;
      default: cond_ok = !alu_neg && !alu_zero;
    endcase
    taken      = pc_write | (pc_write_cond & cond_ok);
    misaligned = ALIGN_CHECK && taken && sel_valid && (target[1:0] != 2'b00);
  end

  // Next-state and next-register values, highest priority event first.
  always_comb begin
    state_n   = state;
    pc_n      = pc_out;
    epc_n     = epc_out;
    cause_n   = cause_out;
    df_n      = double_fault;
    sel_err_n = 1'b0;
    if (exc_req || misaligned) begin
      if (state == RUN) begin
        epc_n   = pc_out - EPC_OFFSET;
        cause_n = exc_req ? exc_cause : CAUSE_MISALIGN;
        pc_n    = EXC_VECTOR + (WIDTH'(cause_n) << 2);
        state_n = HANDLER;
      end else begin
        df_n = 1'b1;
      end
    end else if (eret && state == HANDLER) begin
      pc_n    = epc_out;
      state_n = RUN;
    end else if (taken) begin
      if (sel_valid) pc_n = target;
      else           sel_err_n = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pc_out       <= RESET_PC;
      epc_out      <= '0;
      cause_out    <= '0;
      double_fault <= 1'b0;
      sel_err      <= 1'b0;
    end else begin
      state        <= state_n;
      pc_out       <= pc_n;
      epc_out      <= epc_n;
      cause_out    <= cause_n;
      double_fault <= df_n;
      sel_err      <= sel_err_n;
    end
  end

  assign in_handler = (state == HANDLER);

endmodule

// File: tb/tb_pc_control_unit.sv
// Testbench for pc_control_unit: directed vector table plus random stimulus
// against a behavioural model.
module tb_pc_control_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  src [5];
  logic [159:0] src_bus;
  logic [2:0]   src_sel;
  logic         pc_write, pc_write_cond;
  logic [1:0]   branch_type;
  logic         alu_zero, alu_neg;
  logic         exc_req;
  logic [1:0]   exc_cause;
  logic         eret;
  logic [31:0]  pc_out, epc_out;
  logic [1:0]   cause_out;
  logic         in_handler, double_fault, sel_err;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  bit          m_h, m_df, m_se;

  always #5 clk = ~clk;

  assign src_bus = {src[4], src[3], src[2], src[1], src[0]};

  pc_control_unit #(
    .WIDTH(32), .NSRC(5), .SELW(3), .RESET_PC(32'h0),
    .EXC_VECTOR(32'h0000_00FC), .EPC_OFFSET(32'd4), .ALIGN_CHECK(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .src_bus(src_bus), .src_sel(src_sel),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_type(branch_type), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .exc_req(exc_req), .exc_cause(exc_cause), .eret(eret),
    .pc_out(pc_out), .epc_out(epc_out), .cause_out(cause_out),
    .in_handler(in_handler), .double_fault(double_fault), .sel_err(sel_err)
  );

  typedef struct {
    bit          rst;
    logic [2:0]  sel;
    bit          pw, pwc;
    logic [1:0]  bt;
    bit          z, n, exc;
    logic [1:0]  ec;
    bit          er;
    logic [31:0] pc, epc;
    logic [1:0]  c;
    bit          h, df, se;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit rst, logic [2:0] sel, bit pw, bit pwc,
                              logic [1:0] bt, bit z, bit n, bit exc,
                              logic [1:0] ec, bit er, logic [31:0] pc,
                              logic [31:0] epc, logic [1:0] c, bit h,
                              bit df, bit se);
    vec_t v;
    v.rst = rst; v.sel = sel; v.pw = pw; v.pwc = pwc; v.bt = bt;
    v.z = z; v.n = n; v.exc = exc; v.ec = ec; v.er = er;
    v.pc = pc; v.epc = epc; v.c = c; v.h = h; v.df = df; v.se = se;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic [31:0] pc, logic [31:0] epc,
                            logic [1:0] c, bit h, bit df, bit se);
    check({tag, " pc_out"},       pc_out,               pc);
    check({tag, " epc_out"},      epc_out,              epc);
    check({tag, " cause_out"},    32'(cause_out),       32'(c));
    check({tag, " in_handler"},   32'(in_handler),      32'(h));
    check({tag, " double_fault"}, 32'(double_fault),    32'(df));
    check({tag, " sel_err"},      32'(sel_err),         32'(se));
  endtask

  // Model: one clock of the documented behaviour using current inputs.
  task automatic model_step();
    bit          valid, cond, tk, mis;
    logic [31:0] tgt;
    valid = (src_sel < 3'd5);
    tgt   = valid ? src[src_sel] : 32'h0;
    case (branch_type)
      2'd0: cond = alu_zero;
      2'd1: cond = !alu_zero;
      2'd2: cond = alu_neg || alu_zero;
      default: cond = !alu_neg && !alu_zero;
    endcase
    tk  = pc_write || (pc_write_cond && cond);
    mis = tk && valid && (tgt % 4 != 0);
    m_se = 0;
    if (reset) begin
      m_pc = 0; m_epc = 0; m_cause = 0; m_h = 0; m_df = 0;
    end else if (exc_req || mis) begin
      if (!m_h) begin
        m_epc   = m_pc - 32'd4;
        m_cause = exc_req ? exc_cause : 2'd3;
        m_pc    = 32'd252 + 32'd4 * m_cause;
        m_h     = 1;
      end else begin
        m_df = 1;
      end
    end else if (eret && m_h) begin
      m_pc = m_epc;
      m_h  = 0;
    end else if (tk) begin
      if (valid) m_pc = tgt;
      else       m_se = 1;
    end
  endtask

  task automatic drive(vec_t v);
    reset = v.rst; src_sel = v.sel; pc_write = v.pw; pc_write_cond = v.pwc;
    branch_type = v.bt; alu_zero = v.z; alu_neg = v.n; exc_req = v.exc;
    exc_cause = v.ec; eret = v.er;
  endtask

  initial begin
    vec_t v;
    src[0] = 32'h40; src[1] = 32'h100; src[2] = 32'h200;
    src[3] = 32'h102; src[4] = 32'h300;
    drive(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));

    //        rst sel pw pwc bt z n exc ec er | pc          epc         c h df se
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h0,       32'h0,       0,0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0,0,0, 32'h100,     32'h0,       0,0,0,0));
    vt.push_back(mk(0,2,0,1,1,1,0,0,0,0, 32'h100,     32'h0,       0,0,0,0));
    vt.push_back(mk(0,2,0,1,1,0,0,0,0,0, 32'h200,     32'h0,       0,0,0,0));
    vt.push_back(mk(0,7,1,0,0,0,0,0,0,0, 32'h200,     32'h0,       0,0,0,1));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0, 32'h200,     32'h0,       0,0,0,0));
    vt.push_back(mk(0,4,0,1,0,1,0,0,0,0, 32'h300,     32'h0,       0,0,0,0));
    vt.push_back(mk(0,1,0,1,2,0,1,0,0,0, 32'h100,     32'h0,       0,0,0,0));
    vt.push_back(mk(0,2,0,1,3,0,0,0,0,0, 32'h200,     32'h0,       0,0,0,0));
    vt.push_back(mk(0,4,0,1,3,1,0,0,0,0, 32'h200,     32'h0,       0,0,0,0));
    vt.push_back(mk(0,0,1,0,0,0,0,0,0,0, 32'h40,      32'h0,       0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,1,1,0, 32'h100,     32'h3C,      1,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h3C,      32'h3C,      1,0,0,0));
    vt.push_back(mk(0,3,1,0,0,0,0,0,0,0, 32'h108,     32'h38,      3,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,1,2,1, 32'h108,     32'h38,      3,1,1,0));
    vt.push_back(mk(0,4,1,0,0,0,0,0,0,0, 32'h300,     32'h38,      3,1,1,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h0,       32'h0,       0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,1,2,0, 32'h104,     32'hFFFFFFFC,2,1,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'hFFFFFFFC,32'hFFFFFFFC,2,0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0,0,1, 32'h100,     32'hFFFFFFFC,2,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,1,0,0, 32'hFC,      32'hFC,      0,1,0,0));
    vt.push_back(mk(0,3,1,0,0,0,0,0,0,0, 32'hFC,      32'hFC,      0,1,1,0));
    vt.push_back(mk(0,7,1,0,0,0,0,0,0,0, 32'hFC,      32'hFC,      0,1,1,1));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0, 32'hFC,      32'hFC,      0,1,1,0));

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      drive(v);
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), v.pc, v.epc, v.c, v.h, v.df, v.se);
    end

    // Random phase: begins with a reset so the model starts in a known state.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset         = (cyc == 0) || ($urandom_range(0, 99) == 0);
      src_sel       = 3'($urandom_range(0, 7));
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = ($urandom_range(0, 2) == 0);
      branch_type   = 2'($urandom_range(0, 3));
      alu_zero      = 1'($urandom_range(0, 1));
      alu_neg       = 1'($urandom_range(0, 1));
      exc_req       = ($urandom_range(0, 11) == 0);
      exc_cause     = 2'($urandom_range(0, 2));
      eret          = ($urandom_range(0, 5) == 0);
      for (int s = 0; s < 5; s++) begin
        src[s] = $urandom;
        if ($urandom_range(0, 1) == 1) src[s][1:0] = 2'b00;
      end
      #0;
      model_step();
      @(posedge clk); #1;
      check_outs($sformatf("rnd%0d", cyc), m_pc, m_epc, m_cause, m_h, m_df, m_se);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
